// File: rtl/dcache_nway.sv
// dcache_nway: N-way snooping write-back data cache, MSI coherence, LL/SC.
// Optional hit/miss counters under DCACHE_NWAY_STATS_EN.
module dcache_nway #(
  parameter int NUM_SETS  = 8,
  parameter int NUM_WAYS  = 2,
  parameter int BLK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  output logic        cctrans,
  output logic        ccwrite
`ifdef DCACHE_NWAY_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int BO = $clog2(BLK_WORDS);
  localparam int IB = $clog2(NUM_SETS);
  localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int TB = 30 - BO - IB;
  localparam int SW = $clog2(NUM_SETS * NUM_WAYS);

  typedef enum logic [3:0] {
    IDLE, SNOOP, CCWB, UPGRADE, WB,
    FILLREQ, FILL, CLEAN, FLUSH, HALTED
  } state_t;

  state_t state, nstate;

  logic          valid [NUM_SETS][NUM_WAYS];
  logic          dirty [NUM_SETS][NUM_WAYS];
  logic [TB-1:0] tags  [NUM_SETS][NUM_WAYS];
  logic [31:0]   data  [NUM_SETS][NUM_WAYS][BLK_WORDS];
  logic [WW-1:0] vptr  [NUM_SETS];

  logic [BO-1:0] cnt;
  logic [SW-1:0] sc;
  logic [29:0]   link;
  logic          link_v;
  logic [IB-1:0] sidx;
  logic [WW-1:0] sway;

  logic [TB-1:0] r_tag, s_tag;
  logic [IB-1:0] r_idx, s_idx, sc_set;
  logic [BO-1:0] r_blk;
  logic [WW-1:0] hway, sway_c, vict, sc_way;
  logic          hit, shit, wreq, link_ok, last;

  logic          wr_word, set_link, fill_we, fill_done, inv_vict;
  logic          clr_dirty, snp_inv, lat_snoop;
  logic          cnt_inc, cnt_clr, sc_inc, sc_clr;
  logic [IB-1:0] cd_set;
  logic [WW-1:0] cd_way;

  logic unused_ok;
  assign unused_ok = ^{dmemaddr[1:0], ccsnoopaddr[1:0]};

  assign r_tag   = dmemaddr[31 -: TB];
  assign r_idx   = dmemaddr[2+BO +: IB];
  assign r_blk   = dmemaddr[2 +: BO];
  assign s_tag   = ccsnoopaddr[31 -: TB];
  assign s_idx   = ccsnoopaddr[2+BO +: IB];
  assign sc_set  = IB'(sc / SW'(NUM_WAYS));
  assign sc_way  = WW'(sc % SW'(NUM_WAYS));
  assign vict    = vptr[r_idx];
  assign wreq    = dmemWEN && !dmemREN;
  assign link_ok = link_v && (link == dmemaddr[31:2]);
  assign last    = &cnt;

  always_comb begin
    hit = 1'b0;
    hway = '0;
    shit = 1'b0;
    sway_c = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid[r_idx][w] && tags[r_idx][w] == r_tag) begin
        hit = 1'b1;
        hway = WW'(w);
      end
      if (valid[s_idx][w] && tags[s_idx][w] == s_tag) begin
        shit = 1'b1;
        sway_c = WW'(w);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    dhit = 1'b0;
    dmemload = '0;
    flushed = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    daddr = '0;
    dstore = '0;
    cctrans = 1'b0;
    ccwrite = 1'b0;
    wr_word = 1'b0;
    set_link = 1'b0;
    fill_we = 1'b0;
    fill_done = 1'b0;
    inv_vict = 1'b0;
    clr_dirty = 1'b0;
    snp_inv = 1'b0;
    lat_snoop = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    sc_inc = 1'b0;
    sc_clr = 1'b0;
    cd_set = r_idx;
    cd_way = vict;
    unique case (state)
      IDLE: begin
        if (ccwait) nstate = SNOOP;
        else if (halt) begin
          nstate = CLEAN;
          sc_clr = 1'b1;
        end else if (dmemREN || dmemWEN) begin
          if (wreq && datomic && !link_ok) begin
            dhit = 1'b1;
          end else if (hit && !wreq) begin
            dhit = 1'b1;
            dmemload = data[r_idx][hway][r_blk];
            set_link = datomic;
          end else if (hit && dirty[r_idx][hway]) begin
            dhit = 1'b1;
            dmemload = {31'b0, datomic};
            wr_word = 1'b1;
          end else if (hit) begin
            nstate = UPGRADE;
          end else if (valid[r_idx][vict] && dirty[r_idx][vict]) begin
            nstate = WB;
          end else begin
            nstate = FILLREQ;
          end
        end
      end
      UPGRADE: begin
        cctrans = 1'b1;
        ccwrite = 1'b1;
        daddr = dmemaddr;
        if (ccwait) nstate = SNOOP;
        else if (ccinv) begin
          wr_word = 1'b1;
          dhit = 1'b1;
          dmemload = {31'b0, datomic};
          nstate = IDLE;
        end
      end
      WB: begin
        dWEN = 1'b1;
        ccwrite = 1'b1;
        daddr = {tags[r_idx][vict], r_idx, cnt, 2'b00};
        dstore = data[r_idx][vict][cnt];
        if (!dwait) begin
          cnt_inc = 1'b1;
          if (last) begin
            clr_dirty = 1'b1;
            nstate = FILLREQ;
          end
        end
      end
      FILLREQ: begin
        cctrans = 1'b1;
        dREN = 1'b1;
        daddr = {r_tag, r_idx, {BO{1'b0}}, 2'b00};
        if (ccwait) nstate = SNOOP;
        else if (ccinv) begin
          inv_vict = 1'b1;
          nstate = FILL;
        end
      end
      FILL: begin
        dREN = 1'b1;
        daddr = {r_tag, r_idx, cnt, 2'b00};
        if (!dwait) begin
          cnt_inc = 1'b1;
          fill_we = 1'b1;
          if (last) begin
            fill_done = 1'b1;
            nstate = IDLE;
          end
        end
      end
      SNOOP: begin
        cctrans = 1'b1;
        lat_snoop = 1'b1;
        nstate = IDLE;
        if (shit) begin
          ccwrite = dirty[s_idx][sway_c];
          snp_inv = ccinv;
          if (dirty[s_idx][sway_c]) nstate = CCWB;
        end
      end
      CCWB: begin
        dWEN = 1'b1;
        daddr = {tags[sidx][sway], sidx, cnt, 2'b00};
        dstore = data[sidx][sway][cnt];
        if (!dwait) begin
          cnt_inc = 1'b1;
          if (last) begin
            clr_dirty = 1'b1;
            cd_set = sidx;
            cd_way = sway;
            nstate = IDLE;
          end
        end
      end
      CLEAN: begin
        if (ccwait && !dwait) nstate = SNOOP;
        else if (valid[sc_set][sc_way] && dirty[sc_set][sc_way])
          nstate = FLUSH;
        else if (&sc) nstate = HALTED;
        else sc_inc = 1'b1;
      end
      FLUSH: begin
        dWEN = 1'b1;
        daddr = {tags[sc_set][sc_way], sc_set, cnt, 2'b00};
        dstore = data[sc_set][sc_way][cnt];
        if (!dwait) begin
          if (last) begin
            cnt_inc = 1'b1;
            clr_dirty = 1'b1;
            cd_set = sc_set;
            cd_way = sc_way;
            nstate = CLEAN;
          end else if (ccwait) begin
            // abandon the partial line; CLEAN restarts it from word 0
            cnt_clr = 1'b1;
            nstate = SNOOP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      HALTED: begin
        flushed = 1'b1;
        cctrans = ccwait;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      sc <= '0;
      link <= '0;
      link_v <= 1'b0;
      sidx <= '0;
      sway <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        vptr[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
        end
      end
    end else begin
      if (cnt_clr) cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (sc_clr) sc <= '0;
      else if (sc_inc) sc <= sc + 1'b1;
      if (lat_snoop) begin
        sidx <= s_idx;
        sway <= sway_c;
      end
      if (set_link) begin
        link <= dmemaddr[31:2];
        link_v <= 1'b1;
      end
      if (wr_word) begin
        dirty[r_idx][hway] <= 1'b1;
        if (link == dmemaddr[31:2]) link_v <= 1'b0;
      end
      if (lat_snoop && ccinv && ccsnoopaddr[31:2] == link)
        link_v <= 1'b0;
      if (snp_inv) valid[s_idx][sway_c] <= 1'b0;
      if (inv_vict) valid[r_idx][vict] <= 1'b0;
      if (clr_dirty) dirty[cd_set][cd_way] <= 1'b0;
      if (fill_done) begin
        valid[r_idx][vict] <= 1'b1;
        dirty[r_idx][vict] <= 1'b0;
        tags[r_idx][vict] <= r_tag;
        vptr[r_idx] <= (NUM_WAYS == 1) ? '0 : vict + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_word) data[r_idx][hway][r_blk] <= dmemstore;
    if (fill_we) data[r_idx][vict][cnt] <= dload;
  end

`ifdef DCACHE_NWAY_STATS_EN
  logic st_hit, st_miss;
  assign st_hit  = (state == IDLE) && dhit;
  assign st_miss = (state == IDLE) &&
                   (nstate == WB || nstate == FILLREQ);

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (st_hit && hit_count != '1)
        hit_count <= hit_count + 1'b1;
      if (st_miss && miss_count != '1)
        miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised successor of the team's 2-way, 2-word-block snooping data cache.
- Supports N-way sets, configurable set count and block length, and round-robin replacement.
- Keeps MSI-style snoop coherence and LL/SC link tracking.
- Sits between the datapath memory stage and the coherence controller/bus arbiter. Uses flat ports, not interfaces.

Parameters:
- NUM_SETS, 8, number of sets; power of 2, ≥2.
- NUM_WAYS, 2, associativity; power of 2, ≥1.
- BLK_WORDS, 2, 32-bit words per block; power of 2, ≥2.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- dmemREN  in  1  datapath read request.
- dmemWEN  in  1  datapath write request.
- datomic  in  1  with REN = LL; with WEN = SC.
- dmemaddr  in  32  word address; bits[1:0] ignored.
- dmemstore  in  32  write data.
- halt  in  1  start flush.
- dhit  out  1  request done this cycle.
- dmemload  out  32  read data; SC result (1 = success, 0 = fail).
- flushed  out  1  flush complete.
- dREN  out  1  bus read.
- dWEN  out  1  bus write.
- daddr  out  32  bus address.
- dstore  out  32  bus write data.
- dload  in  32  bus read data.
- dwait  in  1  bus word not done.
- ccwait  in  1  snoop pending against this cache.
- ccinv  in  1  invalidate / grant.
- ccsnoopaddr  in  32  snooped address.
- cctrans  out  1  coherence transaction / snoop ack.
- ccwrite  out  1  line is or will be Modified.

Behaviour:
- Address split: bytoff = [1:0]; blkoff = log2(BLK_WORDS) bits; idx = log2(NUM_SETS) bits; tag = remainder.
- Per line state: valid, dirty, tag, BLK_WORDS data words. Per set: log2(NUM_WAYS)-bit victim pointer; increments modulo NUM_WAYS when a fill completes.
- Reset (next edge with RST=1, even mid-transaction):
  - all valid/dirty bits, victim pointers, link register and word counter cleared; state IDLE.
  - every output is 0 until a new request arrives.
- States: IDLE, SNOOP, CCWB, UPGRADE, WB, FILLREQ, FILL, CLEAN, FLUSH, HALTED. CCWB, WB, FILL and FLUSH step a word counter 0..BLK_WORDS-1; the counter advances only when dwait=0.
- IDLE: priority ccwait > halt > request.
  - ccwait → SNOOP.
  - halt → CLEAN.
  - Read hit: dhit=1 and dmemload valid combinationally in the same cycle.
  - Write hit on a dirty line: dhit=1; word written at the edge.
  - Write hit on a clean line → UPGRADE.
  - Miss with dirty victim → WB; miss with clean victim → FILLREQ.
  - No request → stay in IDLE.
- UPGRADE:
  - Drive cctrans=1, ccwrite=1, daddr=dmemaddr.
  - ccwait=1 → SNOOP; the access retries later.
  - ccinv=1 and ccwait=0 → grant: write word, set dirty, dhit=1, → IDLE.
- WB: dWEN=1, ccwrite=1; victim words written at {victim tag, idx, counter, 00}; after the last word, clear dirty → FILLREQ.
- FILLREQ:
  - Drive cctrans=1, dREN=1, word 0 address.
  - ccwait=1 → SNOOP.
  - ccinv grant → FILL. The victim is marked invalid as soon as FILL begins.
- FILL: dREN=1; words captured from dload. The last word sets valid, writes the tag, clears dirty → IDLE, where the access replays as a hit.
- SNOOP (one cycle): cctrans=1.
  - On tag hit: ccwrite=1 if the line is dirty; ccinv=1 clears valid.
  - Dirty hit → CCWB; otherwise → IDLE.
  - Link cleared if the snoop word address equals the link address and ccinv=1.
- CCWB: dWEN=1; writes the snooped line; after the last word, clear dirty → IDLE.
- LL/SC:
  - An LL read hit loads the link address and sets link-valid.
  - SC completes like a write only if link-valid is set and the address matches the link address; dmemload=1 on success.
  - Otherwise SC gives dhit=1, dmemload=0, and no write or upgrade.
  - Any completed local write to the linked word clears link-valid.
- CLEAN: scans sets 0..NUM_SETS-1 and ways 0..NUM_WAYS-1.
  - A dirty line → FLUSH, which writes BLK_WORDS words, clears dirty, then returns to CLEAN.
  - After the last line → HALTED.
  - ccwait in CLEAN or FLUSH goes to SNOOP only at a word boundary, i.e. dwait=0.
- HALTED: flushed=1; a snoop in HALTED gets cctrans=1 with no state change.
- A simultaneous read and write request is illegal; read has priority.

Optional Feature:
- DCACHE_NWAY_STATS_EN: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments per dhit that needed no bus transaction; miss_count increments per IDLE→WB/FILLREQ transition.
  - Both counters cleared by RST and saturate at 0xFFFFFFFF.
- Without the macro: no ports, no logic.

Test Plan:
- Defaults; read 0x0000_0040 cold → FILLREQ, ccinv grant, 2 fill words 0xA,0xB (dwait 1 cycle each) → dhit with dmemload=0xA; re-read 0x44 → same-cycle dhit, 0xB.
- NUM_WAYS=4: fill 5 distinct tags into idx 0 → fifth fill evicts way 0 (round-robin); a dirty victim produces 2 WB words at the old tag before FILLREQ.
- Write 0x1234 to a clean hit → UPGRADE, cctrans=ccwrite=1; grant → dirty line; snoop same address with ccinv=1 → ccwrite=1, CCWB 2 words carrying 0x1234, line invalid afterwards.
- LL 0x80, SC 0x80 with value 5 → dmemload=1, memory updated; LL 0x80, snoop-invalidate 0x80, SC → dmemload=0, no write.
- Two dirty lines then halt → exactly 4 bus writes, then flushed=1; RST asserted mid-FLUSH → outputs 0 next cycle, state IDLE.
